fixed_point_shift_add_multiplier: RTL and testbench

Sequential unsigned fixed-point multiplier. It computes `A*B` in the same Q-format used by the unsigned long-division block, one shift-and-add step per clock. It pairs with the divider in the fixed-point arithmetic datapath: a product feeds the divider, or a quotient is rescaled through the multiplier. Operands enter and the product leaves through valid/ready handshakes, with round-to-nearest and saturation applied on the way out.

---
 rtl/fixed_point_shift_add_multiplier.sv | 119 +++++++++++
 tb/tb_fixed_point_shift_add_multiplier.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fixed_point_shift_add_multiplier.sv
// Sequential unsigned Q-format multiplier: one shift-and-add step per clock, then
// round-half-up and saturate into a registered, handshaked result.
module fixed_point_shift_add_multiplier #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAC_BITS  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_multiplicand,
  input  logic [DATA_WIDTH-1:0] i_multiplier,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_product,
  output logic                  o_overflow
);

  localparam int unsigned McandW = 2 * DATA_WIDTH;
  localparam int unsigned AccW   = 2 * DATA_WIDTH + 1;
  localparam int unsigned CntW   = $clog2(DATA_WIDTH);
  localparam int unsigned HalfSh = (FRAC_BITS == 0) ? 0 : FRAC_BITS - 1;
  localparam logic [AccW-1:0] Half = (FRAC_BITS == 0) ? '0 : (AccW'(1) << HalfSh);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish, StDone} state_e;

  state_e                state_q, state_d;
  logic [McandW-1:0]     mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] product_q, product_d;
  logic                  overflow_q, overflow_d;

  logic [AccW-1:0] rounded;
  logic [AccW-1:0] scaled;
  logic            sat;

  // The accumulator carries one spare bit, so adding the half-LSB cannot wrap.
  assign rounded = acc_q + Half;
  assign scaled  = rounded >> FRAC_BITS;
  assign sat     = |scaled[AccW-1:DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    valid_d    = valid_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          mcand_d  = McandW'(i_multiplicand);
          mplier_d = i_multiplier;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + AccW'(mcand_q);
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        product_d  = sat ? '1 : scaled[DATA_WIDTH-1:0];
        overflow_d = sat;
        valid_d    = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = valid_q;
  assign o_product  = product_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fixed_point_shift_add_multiplier.sv
// Bench for the shift-add multiplier: directed corner cases plus randomized jobs
// checked against an arithmetic model of round-half-up with saturation.
module tb_fixed_point_shift_add_multiplier;

  localparam int unsigned W = 8;
  localparam int unsigned F = 4;
  localparam int unsigned Latency = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         out_valid;
  logic         in_ready;
  logic [W-1:0] product;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_point_shift_add_multiplier #(
    .DATA_WIDTH(W),
    .FRAC_BITS (F)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_valid       (in_valid),
    .o_ready       (out_ready),
    .i_multiplicand(mcand),
    .i_multiplier  (mplier),
    .o_valid       (out_valid),
    .i_ready       (in_ready),
    .o_product     (product),
    .o_overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, product} = min(round_half_up(A*B / 2^F), 2^W-1).
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = (int'(a) * int'(b) + (1 << (F - 1))) >> F;
    if (p > 255) return {1'b1, 8'hFF};
    return {1'b0, p[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap, input int hold, input string tag);
    logic [W:0] exp;
    int n;
    exp      = model(a, b);
    in_valid = 1'b0;
    in_ready = (hold == 0);
    repeat (gap) step();
    n = 0;
    while (!out_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_ready_before"}, 32'(out_ready), 32'd1);
    mcand    = a;
    mplier   = b;
    in_valid = 1'b1;
    step();
    // Operand noise after the accept edge must not leak into the result.
    in_valid = 1'($urandom_range(0, 1));
    mcand    = W'($urandom);
    mplier   = W'($urandom);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_latency"}, 32'(n), 32'(Latency));
    check({tag, "_product"}, 32'(product), 32'(exp[W-1:0]));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      mcand    = W'($urandom);
      mplier   = W'($urandom);
      step();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(out_ready), 32'd0);
      check({tag, "_hold_product"}, 32'(product), 32'(exp[W-1:0]));
      check({tag, "_hold_overflow"}, 32'(overflow), 32'(exp[W]));
    end
    in_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(out_ready), 32'd1);
    in_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    mcand    = '0;
    mplier   = '0;
    repeat (2) step();
    rst_n = 1'b1;
    check("reset_ready", 32'(out_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    run_job(8'h28, 8'h18, 0, 0, "basic");
    check("basic_value", 32'(product), 32'h3C);
    run_job(8'h01, 8'h08, 0, 0, "half_up");
    check("half_up_value", 32'(product), 32'h01);
    run_job(8'h01, 8'h07, 0, 0, "below_half");
    check("below_half_value", 32'(product), 32'h00);
    run_job(8'h00, 8'hFF, 0, 0, "zero");
    run_job(8'hF0, 8'h20, 0, 0, "saturate");
    check("saturate_value", 32'(product), 32'hFF);
    check("saturate_flag", 32'(overflow), 32'd1);
    run_job(8'h10, 8'h10, 0, 0, "after_sat");
    check("after_sat_value", 32'(product), 32'h10);
    check("after_sat_flag", 32'(overflow), 32'd0);
    run_job(8'hF0, 8'h20, 1, 5, "backpressure");

    // Abort a job four edges into RUN; the reset must wipe the previous result too.
    in_ready = 1'b1;
    mcand    = 8'h28;
    mplier   = 8'h18;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check("midrst_ready", 32'(out_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();
    check("midrst_no_result", 32'(out_valid), 32'd0);
    run_job(8'h18, 8'h28, 0, 0, "fresh");
    check("fresh_value", 32'(product), 32'h3C);

    for (int j = 0; j < 100; j++) begin
      run_job(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
